serial_bcd_alu_n: RTL and testbench
===================================

Name: serial_bcd_alu_n

Overview:
Parametrised, digit-serial successor of the team's serialized BCD ALU. It frame-syncs on a serial input stream and captures an op plus two DIGITS-wide BCD operands. It computes add or signed-magnitude subtract one digit per cycle and serialises a headered result frame with status flags. It sits between the serial line receiver and transmitter, with explicit busy/valid signalling in place of free-running shift registers.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal 1..16)
HDR_IN, 8'hA5, input frame sync header, MSB first
HDR_OUT, 8'h96, output frame header, MSB first

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
din  input  1  serial input, sampled every rising edge
dout  output  1  serial result bit, MSB first
dout_valid  output  1  high on every cycle dout carries a frame bit
busy  output  1  high in CALC, NEG and SEND; din is ignored while high

Behaviour:
- Input frame, MSB first: HDR_IN[7:0], op[1:0], A[4*DIGITS-1:0], B[4*DIGITS-1:0]. Op codes: 00 = add, 01 = sub, 1x = invalid.
- Output frame, MSB first: HDR_OUT[7:0], status[3:0] = {neg, carry, bad_digit, bad_op}, R[4*(DIGITS+1)-1:0]. Output length OUT_BITS = 12 + 4*(DIGITS+1).
- Reset: state HUNT; header window, counters and operand/result registers cleared; dout = 0, dout_valid = 0, busy = 0. Reset mid-frame aborts it; dout_valid is low in the cycle after reset is sampled, and no partial frame resumes.
- HUNT: window <= {window[6:0], din}. When {window[6:0], din} == HDR_IN, go to RECV with bit counter = 0. Overlapping headers are allowed.
- RECV: shift 2 + 8*DIGITS bits into the capture register. On the edge sampling the last bit, go to CALC with digit index = 0.
- CALC: exactly DIGITS cycles, LSD first, one bcd_digit_add per cycle.
  - Add: carry-in 0.
  - Sub: add A to the 9's complement of B, carry-in 1.
  - Digit sums above 9 are corrected by +6 (equivalently −10) and generate carry.
  - Add: R = {000, final carry, sum digits}; carry flag = final carry.
  - Sub with final carry 1 (A >= B): R = {0000, sum digits}, neg = 0, carry = 0.
  - Sub with final carry 0: go to NEG.
- NEG: exactly DIGITS cycles, in-place 10's complement of the sum digits (9's complement, +1 at the LSD, digit-serial carry). Then neg = 1 and R = {0000, magnitude}.
- Error handling: if any captured digit of A or B is > 9, bad_digit = 1. If op is 1x, bad_op = 1. In either case CALC still runs its full DIGITS cycles so latency stays fixed; NEG is skipped; R = 0, neg = 0, carry = 0.
- SEND: dout/dout_valid are registered. The first header bit appears on the cycle after CALC or NEG completes, followed by exactly OUT_BITS consecutive valid cycles. Then go to HUNT with the window cleared, so stale bits cannot fake a header.
- Latency from the edge sampling the last operand bit to the first dout_valid: DIGITS+1 cycles, or 2*DIGITS+1 for a negative subtract.
- 0 − 0 gives neg = 0, R = 0.
- dout = 0 whenever dout_valid = 0.
- busy rises on the CALC entry edge and falls on the last SEND cycle. The first HUNT sample is the cycle after that.

Decomposition:
- Package serial_bcd_pkg holds:
  - state enum (HUNT, RECV, CALC, NEG, SEND)
  - op codes OP_ADD / OP_SUB
  - status bit index constants
  - default HDR_IN / HDR_OUT
  - width helpers for in-frame and out-frame length
- One sub-module, bcd_digit_add: combinational 4-bit + 4-bit + carry-in, producing a corrected digit and carry-out. It is shared by CALC and NEG.

Test Plan (DIGITS = 4):
- Add: frame A5, 00, 1234, 5678 -> after 5 cycles, 96, status 0000, R = 06912; exactly 32 valid bits.
- Add with carry: 9999 + 0001 -> status 0100, R = 10000.
- Positive sub: 5000 − 1234 -> status 0000, R = 03766, latency 5 cycles.
- Negative sub: 1234 − 5000 -> status 1000, R = 03766, latency 9 cycles. Also 0000 − 0000 -> status 0000, R = 00000.
- Errors: A = 12A4 with op 00 -> status 0010, R = 00000, latency 5. Op 10 with valid digits -> status 0001, R = 00000.
- Framing and reset:
  - A5 pattern injected during busy -> ignored.
  - Reset asserted mid-RECV, then a clean frame -> correct single result.
  - Two back-to-back frames -> two correct results.
  - Reset mid-SEND -> dout_valid low on the next cycle.

Source files
------------

// File: rtl/serial_bcd_alu_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bcd_pkg
//  Description : Shared types and constants for the digit-serial BCD ALU:
//                FSM state encoding, op codes, status bit positions,
//                default frame headers and frame-length helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_bcd_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    RECV = 3'd1,
    CALC = 3'd2,
    NEG  = 3'd3,
    SEND = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // Bit positions inside the 4-bit status field {neg, carry, bad_digit, bad_op}
  localparam int STAT_NEG       = 3;
  localparam int STAT_CARRY     = 2;
  localparam int STAT_BAD_DIGIT = 1;
  localparam int STAT_BAD_OP    = 0;

  localparam logic [7:0] DEFAULT_HDR_IN  = 8'hA5;
  localparam logic [7:0] DEFAULT_HDR_OUT = 8'h96;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Payload bits following the input header: op plus two operands
  function automatic int in_frame_bits(input int digits);
    return 2 + 8 * digits;
  endfunction

  // Full output frame: header, status, result with one extra digit
  function automatic int out_frame_bits(input int digits);
    return 12 + 4 * (digits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bcd_alu_n_bcd_digit_add.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_add
//  Description : Combinational single-digit BCD adder: a + b + cin with
//                decimal correction; carry-out set for binary sums above 9.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add
  import serial_bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  // Binary add, then +6 (mod 16) folds 10..19 back into a valid digit
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > {1'b0, BCD_MAX});
    sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
  end

endmodule
`default_nettype wire

// File: rtl/serial_bcd_alu_n.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bcd_alu_n
//  Description : Digit-serial BCD add / signed-magnitude subtract. Hunts for
//                an input header, captures op and two operands, computes one
//                digit per cycle (plus an optional 10's-complement pass for
//                negative differences) and serialises a headered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bcd_alu_n
  import serial_bcd_pkg::*;
#(
  parameter int         DIGITS  = 4,
  parameter logic [7:0] HDR_IN  = DEFAULT_HDR_IN,
  parameter logic [7:0] HDR_OUT = DEFAULT_HDR_OUT
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic dout_valid,
  output logic busy
);

  localparam int IN_BITS  = in_frame_bits(DIGITS);
  localparam int OUT_BITS = out_frame_bits(DIGITS);
  localparam int RES_W    = 4 * DIGITS;
  localparam int MAX_BITS = (IN_BITS > OUT_BITS) ? IN_BITS : OUT_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [6:0]          window_q, window_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_BITS-1:0]  cap_q, cap_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic                carry_q, carry_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [OUT_BITS-1:0] out_q, out_d;
  logic                dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;

  logic [1:0]          op;
  logic                is_sub;
  logic                bad_op;
  logic                bad_digit;
  logic [3:0]          a_dig;
  logic [3:0]          b_dig;
  logic [3:0]          r_dig;
  logic                first_dig;
  logic                last_dig;
  logic [3:0]          add_a;
  logic [3:0]          add_b;
  logic                add_cin;
  logic [3:0]          add_sum;
  logic                add_cout;
  logic [RES_W-1:0]    res_upd;
  logic [7:0]          hunt_win;
  logic [3:0]          status;

  // Decode the captured frame and select the digits for the current index
  always_comb begin
    op        = cap_q[IN_BITS-1 -: 2];
    is_sub    = (op == OP_SUB);
    bad_op    = op[1];
    bad_digit = 1'b0;
    a_dig     = '0;
    b_dig     = '0;
    r_dig     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((cap_q[RES_W + 4*i +: 4] > BCD_MAX) || (cap_q[4*i +: 4] > BCD_MAX)) begin
        bad_digit = 1'b1;
      end
      if (dig_q == DIG_W'(i)) begin
        a_dig = cap_q[RES_W + 4*i +: 4];
        b_dig = cap_q[4*i +: 4];
        r_dig = res_q[4*i +: 4];
      end
    end
    first_dig = (dig_q == '0);
    last_dig  = (dig_q == DIG_W'(DIGITS - 1));
  end

  // Adder operand mux: A +/- B during CALC, 9's complement + 1 chain during NEG
  always_comb begin
    if (state_q == NEG) begin
      add_a   = BCD_MAX - r_dig;
      add_b   = '0;
      add_cin = first_dig ? 1'b1 : carry_q;
    end else begin
      add_a   = a_dig;
      add_b   = is_sub ? (BCD_MAX - b_dig) : b_dig;
      add_cin = first_dig ? is_sub : carry_q;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, datapath updates and registered serial output
  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    dig_d        = dig_q;
    carry_d      = carry_q;
    res_d        = res_q;
    out_d        = out_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    status       = '0;
    hunt_win     = {window_q, din};
    for (int i = 0; i < DIGITS; i++) begin
      res_upd[4*i +: 4] = (dig_q == DIG_W'(i)) ? add_sum : res_q[4*i +: 4];
    end

    case (state_q)
      HUNT: begin
        window_d = hunt_win[6:0];
        if (hunt_win == HDR_IN) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end

      RECV: begin
        cap_d = {cap_q[IN_BITS-2:0], din};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_BITS - 1)) begin
          state_d = CALC;
          dig_d   = '0;
          cnt_d   = '0;
        end
      end

      CALC: begin
        res_d   = res_upd;
        carry_d = add_cout;
        dig_d   = dig_q + DIG_W'(1);
        if (last_dig) begin
          dig_d = '0;
          cnt_d = '0;
          if (bad_op || bad_digit) begin
            // Errors still spend the full CALC time so latency is fixed
            status[STAT_BAD_DIGIT] = bad_digit;
            status[STAT_BAD_OP]    = bad_op;
            res_d   = '0;
            out_d   = {HDR_OUT, status, {(RES_W + 4){1'b0}}};
            state_d = SEND;
          end else if (!is_sub) begin
            status[STAT_CARRY] = add_cout;
            out_d   = {HDR_OUT, status, 3'b000, add_cout, res_upd};
            state_d = SEND;
          end else if (add_cout) begin
            // Carry out of a subtract means A >= B: sum is the magnitude
            out_d   = {HDR_OUT, status, 4'b0000, res_upd};
            state_d = SEND;
          end else begin
            state_d = NEG;
          end
        end
      end

      NEG: begin
        res_d   = res_upd;
        carry_d = add_cout;
        dig_d   = dig_q + DIG_W'(1);
        if (last_dig) begin
          dig_d            = '0;
          cnt_d            = '0;
          status[STAT_NEG] = 1'b1;
          out_d            = {HDR_OUT, status, 4'b0000, res_upd};
          state_d          = SEND;
        end
      end

      SEND: begin
        dout_d       = out_q[OUT_BITS-1];
        dout_valid_d = 1'b1;
        out_d        = {out_q[OUT_BITS-2:0], 1'b0};
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_BITS - 1)) begin
          // Clear the window so pre-busy bits cannot combine into a header
          state_d  = HUNT;
          window_d = '0;
          cnt_d    = '0;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      window_q     <= '0;
      cnt_q        <= '0;
      cap_q        <= '0;
      dig_q        <= '0;
      carry_q      <= 1'b0;
      res_q        <= '0;
      out_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      dig_q        <= dig_d;
      carry_q      <= carry_d;
      res_q        <= res_d;
      out_q        <= out_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == CALC) || (state_q == NEG) || (state_q == SEND);

endmodule
`default_nettype wire

// File: tb/tb_serial_bcd_alu_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bcd_alu_n
//  Description : Directed, table-driven bench for serial_bcd_alu_n with
//                DIGITS = 4, plus framing / reset corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bcd_alu_n;

  logic clk;
  logic reset;
  logic din;
  logic dout;
  logic dout_valid;
  logic busy;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  st;
    logic [19:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  serial_bcd_alu_n #(
    .DIGITS  (4),
    .HDR_IN  (8'hA5),
    .HDR_OUT (8'h96)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the top nbits of f, MSB first, one bit per cycle
  task automatic send_bits(input logic [41:0] f, input int nbits);
    for (int i = 41; i > 41 - nbits; i--) begin
      @(negedge clk);
      din = f[i];
    end
  endtask

  task automatic idle_check(input string name, input int n);
    int seen;
    seen = 0;
    din  = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (dout_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  // Send one frame, then measure latency and collect the result frame
  task automatic run_frame(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] est, input logic [19:0] er, input int elat,
                           input bit inject, input string tag);
    logic [41:0] f;
    logic [31:0] got;
    logic [7:0]  pat;
    int          k;
    int          nvalid;
    f      = {8'hA5, op, a, b};
    pat    = 8'hA5;
    got    = '0;
    nvalid = 0;
    k      = 0;
    send_bits(f, 42);
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) check({tag, ".busy"}, busy, 1);
      if (dout_valid) break;
      din = (inject && busy) ? pat[7] : 1'b0;
      pat = {pat[6:0], pat[7]};
    end
    check({tag, ".latency"}, k - 1, elat);
    if (!dout_valid) return;
    for (int j = 0; j < 32; j++) begin
      if (j > 0) @(negedge clk);
      got = {got[30:0], dout};
      if (dout_valid) nvalid++;
      din = (inject && busy) ? pat[7] : 1'b0;
      pat = {pat[6:0], pat[7]};
    end
    @(negedge clk);
    din = 1'b0;
    check({tag, ".trail_valid"}, dout_valid, 0);
    check({tag, ".nvalid"}, nvalid, 32);
    check({tag, ".header"}, got[31:24], 8'h96);
    check({tag, ".status"}, got[23:20], est);
    check({tag, ".result"}, got[19:0], er);
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    din      = 1'b0;

    //          op     A        B        status   R           latency
    vecs[0] = '{2'b00, 16'h1234, 16'h5678, 4'b0000, 20'h06912, 5};
    vecs[1] = '{2'b00, 16'h9999, 16'h0001, 4'b0100, 20'h10000, 5};
    vecs[2] = '{2'b01, 16'h5000, 16'h1234, 4'b0000, 20'h03766, 5};
    vecs[3] = '{2'b01, 16'h1234, 16'h5000, 4'b1000, 20'h03766, 9};
    vecs[4] = '{2'b01, 16'h0000, 16'h0000, 4'b0000, 20'h00000, 5};
    vecs[5] = '{2'b00, 16'h12A4, 16'h0001, 4'b0010, 20'h00000, 5};
    vecs[6] = '{2'b10, 16'h1234, 16'h1111, 4'b0001, 20'h00000, 5};
    vecs[7] = '{2'b01, 16'h0999, 16'h1000, 4'b1000, 20'h00001, 9};
    vecs[8] = '{2'b11, 16'h9999, 16'hA000, 4'b0011, 20'h00000, 5};
    vecs[9] = '{2'b00, 16'h4821, 16'h3179, 4'b0000, 20'h08000, 5};

    repeat (3) @(negedge clk);
    check("reset.dout", dout, 0);
    check("reset.dout_valid", dout_valid, 0);
    check("reset.busy", busy, 0);
    reset = 1'b0;

    // Table vectors, sent back to back
    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].st, vecs[i].r, vecs[i].lat,
                1'b0, $sformatf("v%0d", i));
    end

    // Header pattern driven while busy must be ignored
    run_frame(2'b01, 16'h1234, 16'h5000, 4'b1000, 20'h03766, 9, 1'b1, "inject");
    idle_check("inject.idle", 60);

    // Leading junk overlapping the header
    send_bits({4'b1010, 38'b0}, 4);
    run_frame(2'b00, 16'h9999, 16'h0001, 4'b0100, 20'h10000, 5, 1'b0, "overlap");

    // Reset during RECV, then a clean frame gives exactly one result
    send_bits({8'hA5, 2'b00, 16'h1111, 16'h2222}, 18);
    @(negedge clk);
    reset = 1'b1;
    din   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_frame(2'b00, 16'h1234, 16'h5678, 4'b0000, 20'h06912, 5, 1'b0, "rrecv");
    idle_check("rrecv.idle", 60);

    // Reset during SEND kills dout_valid on the next cycle
    send_bits({8'hA5, 2'b00, 16'h1234, 16'h5678}, 42);
    k = 0;
    while (!dout_valid && k < 60) begin
      @(negedge clk);
      din = 1'b0;
      k++;
    end
    check("rsend.reached", dout_valid, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rsend.dout_valid", dout_valid, 0);
    check("rsend.dout", dout, 0);
    check("rsend.busy", busy, 0);
    reset = 1'b0;
    idle_check("rsend.idle", 60);

    run_frame(2'b01, 16'h5000, 16'h1234, 4'b0000, 20'h03766, 5, 1'b0, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
